// File: rtl/csa_resolve_pipe_pkg.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe_pkg
//
// Shared constants for the Booth-Wallace multiplier datapath.
//   CSA_WIDTH_DEF      : default width of the carry-save (S, C) vectors
//   CSA_TAG_W_DEF      : default width of the per-operation sideband tag
//   csa_resolved_width : width of the binary sum once (S, C) is resolved.
//                        The Wallace top and the product consumer both size
//                        their product buses with this function.
// -----------------------------------------------------------------------------
package csa_resolve_pipe_pkg;

    localparam int CSA_WIDTH_DEF = 32;
    localparam int CSA_TAG_W_DEF = 4;

    // S + 2*C peaks at 3*2^W - 3, which needs exactly two bits more than S.
    function automatic int csa_resolved_width(input int width);
        return width + 2;
    endfunction

endpackage : csa_resolve_pipe_pkg

// File: rtl/csa_resolve_pipe_cpa_segment.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe_cpa_segment
//
// N-bit carry-propagate adder segment: {cout_o, sum_o} = a_i + b_i + cin_i.
// Built as a plain ripple chain. The pipeline control in csa_resolve_pipe
// only depends on this port list, so a carry-lookahead or prefix segment can
// be dropped in here later without touching the stage logic.
//
// Ports:
//   a_i    [N-1:0]  first operand
//   b_i    [N-1:0]  second operand
//   cin_i           carry into bit 0
//   sum_o  [N-1:0]  sum bits
//   cout_o          carry out of bit N-1
// -----------------------------------------------------------------------------
module csa_resolve_pipe_cpa_segment #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic p;
        assign p            = a_i[i] ^ b_i[i];
        assign sum_o[i]     = p ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (p & carry[i]);
    end

    assign cout_o = carry[N];

endmodule : csa_resolve_pipe_cpa_segment

// File: rtl/csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe
//
// Resolves the redundant (S, C) pair from the final Wallace tree row into a
// binary sum, sum_out = s_in + 2*c_in, exact and never truncated. The
// carry-propagate add is split across two pipeline stages: stage 1 adds the
// low LO_W bits and registers the segment carry, stage 2 adds the high bits
// with that carry. Latency is 2 cycles, throughput 1 per cycle.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds its data while valid is
// high and ready is low; out_valid never drops without a transfer and
// sum_out/tag_out are stable while out_valid && !out_ready. in_ready depends
// combinationally on out_ready only (never on the data inputs).
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, flushes both stages
//   in_valid   s_in/c_in/tag_in carry an operation
//   in_ready   the operation is accepted this cycle
//   s_in       [WIDTH-1:0]  sum vector, bit i weight 2^i
//   c_in       [WIDTH-1:0]  carry vector, bit i weight 2^(i+1)
//   tag_in     [TAG_W-1:0]  sideband, passed through unchanged
//   out_valid  sum_out/tag_out carry a result
//   out_ready  consumer takes the result this cycle
//   sum_out    [WIDTH+1:0]  s_in + 2*c_in
//   tag_out    [TAG_W-1:0]  tag belonging to sum_out
// -----------------------------------------------------------------------------
module csa_resolve_pipe
    import csa_resolve_pipe_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH_DEF,  // even, >= 4
    parameter int TAG_W = CSA_TAG_W_DEF   // >= 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   s_in,
    input  logic [WIDTH-1:0]   c_in,
    input  logic [TAG_W-1:0]   tag_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH+1:0]   sum_out,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int LO_W  = WIDTH / 2;
    localparam int HI_W  = WIDTH - LO_W;
    localparam int OUT_W = csa_resolved_width(WIDTH);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic ready1;
    logic ready2;
    logic accept;
    logic advance;

    // Stage 1 register state
    logic [LO_W-1:0]  lo_q,     lo_d;
    logic             k_q,      k_d;
    logic [HI_W-1:0]  s_hi_q,   s_hi_d;
    logic [HI_W:0]    c_hi_q,   c_hi_d;
    logic [TAG_W-1:0] tag1_q,   tag1_d;
    logic             v1_q,     v1_d;

    // Stage 2 register state
    logic [OUT_W-1:0] sum_q,    sum_d;
    logic [TAG_W-1:0] tag2_q,   tag2_d;
    logic             v2_q,     v2_d;

    assign ready2   = !v2_q || out_ready;
    assign ready1   = !v1_q || ready2;
    assign in_ready = ready1;
    assign accept   = in_valid && ready1;
    assign advance  = v1_q && ready2;

    // ------------------------------------------------------------------
    // Stage 1 arithmetic: low segment of S + 2C
    // ------------------------------------------------------------------
    // C is a raw carry-out vector, so its bit i lands at sum bit i+1. The
    // low segment therefore takes c_in[LO_W-2:0] shifted up by one, and
    // c_in[LO_W-1] belongs to the high segment.
    logic [LO_W-1:0] lo_c_shift;
    logic [LO_W-1:0] lo_sum;
    logic            lo_cout;

    assign lo_c_shift = {c_in[LO_W-2:0], 1'b0};

    csa_resolve_pipe_cpa_segment #(
        .N (LO_W)
    ) u_cpa_lo (
        .a_i    (s_in[LO_W-1:0]),
        .b_i    (lo_c_shift),
        .cin_i  (1'b0),
        .sum_o  (lo_sum),
        .cout_o (lo_cout)
    );

    // ------------------------------------------------------------------
    // Stage 2 arithmetic: high segment plus the registered segment carry
    // ------------------------------------------------------------------
    // s_hi has HI_W bits, c_hi has HI_W+1 bits (it starts one position
    // lower in C), so the segment runs at HI_W+1 bits and its carry-out
    // becomes the top result bit: HI_W+2 bits in total.
    logic [HI_W:0]   hi_a;
    logic [HI_W:0]   hi_sum;
    logic            hi_cout;
    logic [HI_W+1:0] hi;

    assign hi_a = {1'b0, s_hi_q};

    csa_resolve_pipe_cpa_segment #(
        .N (HI_W + 1)
    ) u_cpa_hi (
        .a_i    (hi_a),
        .b_i    (c_hi_q),
        .cin_i  (k_q),
        .sum_o  (hi_sum),
        .cout_o (hi_cout)
    );

    assign hi = {hi_cout, hi_sum};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        lo_d   = lo_q;
        k_d    = k_q;
        s_hi_d = s_hi_q;
        c_hi_d = c_hi_q;
        tag1_d = tag1_q;
        v1_d   = v1_q;

        // A new accept overwrites stage 1 in the same cycle it advances.
        if (accept) begin
            lo_d   = lo_sum;
            k_d    = lo_cout;
            s_hi_d = s_in[WIDTH-1:LO_W];
            c_hi_d = c_in[WIDTH-1:LO_W-1];
            tag1_d = tag_in;
            v1_d   = 1'b1;
        end else if (advance) begin
            v1_d   = 1'b0;
        end
    end

    always_comb begin
        sum_d  = sum_q;
        tag2_d = tag2_q;
        v2_d   = v2_q;

        if (advance) begin
            sum_d  = {hi, lo_q};
            tag2_d = tag1_q;
            v2_d   = 1'b1;
        end else if (out_ready) begin
            // Output taken (or already empty) with nothing to replace it.
            v2_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q   <= '0;
            k_q    <= 1'b0;
            s_hi_q <= '0;
            c_hi_q <= '0;
            tag1_q <= '0;
            v1_q   <= 1'b0;
            sum_q  <= '0;
            tag2_q <= '0;
            v2_q   <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            k_q    <= k_d;
            s_hi_q <= s_hi_d;
            c_hi_q <= c_hi_d;
            tag1_q <= tag1_d;
            v1_q   <= v1_d;
            sum_q  <= sum_d;
            tag2_q <= tag2_d;
            v2_q   <= v2_d;
        end
    end

    assign out_valid = v2_q;
    assign sum_out   = sum_q;
    assign tag_out   = tag2_q;

endmodule : csa_resolve_pipe

// File: tb/tb_csa_resolve_pipe.sv
module tb_csa_resolve_pipe;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int OW = W + 2;
  localparam int EW = OW + TW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  s_in;
  logic [W-1:0]  c_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] sum_out;
  logic [TW-1:0] tag_out;

  csa_resolve_pipe #(
    .WIDTH (W),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .tag_out   (tag_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  logic [EW-1:0] exp_q[$];

  // reference: tag and exact s + 2c
  function automatic logic [EW-1:0] model(input logic [W-1:0] s, input logic [W-1:0] c,
                                          input logic [TW-1:0] t);
    logic [OW-1:0] r;
    r = {2'b00, s} + {1'b0, c, 1'b0};
    return {t, r};
  endfunction

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] s, input logic [W-1:0] c,
                       input logic [TW-1:0] t);
    in_valid = v;
    s_in     = s;
    c_in     = c;
    tag_in   = t;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (sum_out !== 10'h000) begin
      n_fail++; $display("FAIL reset_sum_out: got %h expected 000", sum_out);
    end
    n_checks++;
    if (tag_out !== 4'h0) begin
      n_fail++; $display("FAIL reset_tag_out: got %h expected 0", tag_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_corners();
    logic [W-1:0]  vs[4];
    logic [W-1:0]  vc[4];
    logic [TW-1:0] vt[4];
    logic [OW-1:0] vx[4];
    vs[0] = 8'h00; vc[0] = 8'h00; vt[0] = 4'h1; vx[0] = 10'h000;
    vs[1] = 8'h0F; vc[1] = 8'h01; vt[1] = 4'h2; vx[1] = 10'h011;
    vs[2] = 8'h00; vc[2] = 8'h80; vt[2] = 4'h3; vx[2] = 10'h100;
    vs[3] = 8'hFF; vc[3] = 8'hFF; vt[3] = 4'h4; vx[3] = 10'h2FD;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      drive(1'b1, vs[i], vc[i], vt[i]);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL corner%0d_in_ready: got %b expected 1", i, in_ready);
      end
      tick();
      drive(1'b0, '0, '0, '0);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL corner%0d_early_valid: got %b expected 0", i, out_valid);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL corner%0d_latency: out_valid got %b expected 1", i, out_valid);
      end
      n_checks++;
      if (sum_out !== vx[i]) begin
        n_fail++; $display("FAIL corner%0d_sum: got %h expected %h", i, sum_out, vx[i]);
      end
      n_checks++;
      if (tag_out !== vt[i]) begin
        n_fail++; $display("FAIL corner%0d_tag: got %h expected %h", i, tag_out, vt[i]);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL corner%0d_drop: out_valid got %b expected 0", i, out_valid);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [W-1:0]  s;
    logic [W-1:0]  c;
    logic [TW-1:0] t;
    logic [EW-1:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (cyc < 16) begin
        s = W'($urandom_range(0, 255));
        c = W'($urandom_range(0, 255));
        t = TW'($urandom_range(0, 15));
        drive(1'b1, s, c, t);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, in_ready);
        end
        exp_q.push_back(model(s, c, t));
      end else begin
        drive(1'b0, '0, '0, '0);
        #1;
      end
      if (cyc >= 2) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || {tag_out, sum_out} !== e) begin
          n_fail++;
          $display("FAIL b2b_out cyc %0d: got valid %b tag/sum %h expected valid 1 tag/sum %h",
                   cyc, out_valid, {tag_out, sum_out}, e);
        end
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 4'h5);   // -> 0x07A
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept_a: in_ready got %b expected 1", in_ready);
    end
    tick();
    drive(1'b1, 8'hAB, 8'h55, 4'h6);   // -> 0x155
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept_b: in_ready got %b expected 1", in_ready);
    end
    tick();
    drive(1'b1, 8'hF0, 8'h0F, 4'h7);   // -> 0x10E
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_full%0d: in_ready got %b expected 0", i, in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b1 || sum_out !== 10'h07A || tag_out !== 4'h5) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid %b sum %h tag %h expected valid 1 sum 07a tag 5",
                 i, out_valid, sum_out, tag_out);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: in_ready got %b expected 1", in_ready);
    end
    tick();
    drive(1'b0, '0, '0, '0);
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 10'h155 || tag_out !== 4'h6) begin
      n_fail++;
      $display("FAIL bp_second: got valid %b sum %h tag %h expected valid 1 sum 155 tag 6",
               out_valid, sum_out, tag_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 10'h10E || tag_out !== 4'h7) begin
      n_fail++;
      $display("FAIL bp_third: got valid %b sum %h tag %h expected valid 1 sum 10e tag 7",
               out_valid, sum_out, tag_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    int            n_sent;
    int            n_recv;
    int            cyc;
    logic          have_vec;
    logic [W-1:0]  cs;
    logic [W-1:0]  cc;
    logic [TW-1:0] ct;
    logic          prev_stall;
    logic [EW-1:0] prev_data;
    logic [EW-1:0] e;
    n_sent = 0;
    n_recv = 0;
    cyc = 0;
    have_vec = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    cs = '0; cc = '0; ct = '0;
    exp_q.delete();
    while (n_recv < 1000 && cyc < 20000) begin
      // a stalled output must still be there, unchanged
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || {tag_out, sum_out} !== prev_data) begin
          n_fail++;
          $display("FAIL rnd_stall cyc %0d: got valid %b tag/sum %h expected valid 1 tag/sum %h",
                   cyc, out_valid, {tag_out, sum_out}, prev_data);
        end
      end
      if (!have_vec && n_sent < 1000) begin
        cs = W'($urandom_range(0, 255));
        cc = W'($urandom_range(0, 255));
        ct = TW'($urandom_range(0, 15));
        have_vec = 1'b1;
      end
      drive(have_vec && ($urandom_range(0, 3) != 0), cs, cc, ct);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(cs, cc, ct));
        n_sent++;
        have_vec = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra cyc %0d: got tag/sum %h with nothing expected", cyc,
                   {tag_out, sum_out});
        end else begin
          e = exp_q.pop_front();
          if ({tag_out, sum_out} !== e) begin
            n_fail++;
            $display("FAIL rnd_data op %0d: got tag/sum %h expected %h", n_recv,
                     {tag_out, sum_out}, e);
          end
        end
        n_recv++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = {tag_out, sum_out};
      tick();
      cyc++;
    end
    n_checks++;
    if (n_recv != 1000) begin
      n_fail++; $display("FAIL rnd_timeout: received %0d expected 1000", n_recv);
    end
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h22, 4'hA);
    tick();
    drive(1'b1, 8'h33, 8'h44, 4'hB);
    tick();
    drive(1'b0, '0, '0, '0);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_full: got valid %b in_ready %b expected valid 1 in_ready 0",
               out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || sum_out !== 10'h000 || tag_out !== 4'h0) begin
      n_fail++;
      $display("FAIL mrst_flush: got valid %b sum %h tag %h expected valid 0 sum 000 tag 0",
               out_valid, sum_out, tag_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mrst_in_ready: got %b expected 1", in_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    drive(1'b1, 8'h01, 8'h01, 4'h9);
    tick();
    drive(1'b0, '0, '0, '0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_early: out_valid got %b expected 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || sum_out !== 10'h003 || tag_out !== 4'h9) begin
      n_fail++;
      $display("FAIL mrst_new_op: got valid %b sum %h tag %h expected valid 1 sum 003 tag 9",
               out_valid, sum_out, tag_out);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mrst_no_stale: out_valid got %b expected 0", out_valid);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    in_valid  = 1'b0;
    s_in      = '0;
    c_in      = '0;
    tag_in    = '0;
    out_ready = 1'b0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_csa_resolve_pipe
